// File: rtl/jam_perm_seq_pkg.sv
// Shared constants and state encoding for the permutation sequencer.
// Ports: none (package). Imported by next_perm and jam_perm_seq.
package jam_pkg;

    localparam int N_WORKERS = 8;
    localparam int IDX_W     = 3;
    localparam int PERM_W    = 16;
    localparam int ORDER_W   = N_WORKERS * IDX_W;

    localparam logic [3:0] CNT_LAST = 4'd9;
    localparam logic [3:0] CNT_IDLE = 4'd10;

    // Identity (worker i -> job i) and the final descending permutation.
    localparam logic [ORDER_W-1:0] ORDER_INIT = 24'hFAC688;
    localparam logic [ORDER_W-1:0] ORDER_LAST = 24'h053977;
    localparam int                 PERM_TOTAL = 40320;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        RUN  = ST_RUN,
        DONE = ST_DONE
    } state_e;

endpackage

// File: rtl/jam_perm_seq_if.sv
// Signals between the permutation sequencer and the cost accumulator.
//   start    : pulse from the consumer side to begin enumeration
//   cnt      : phase counter 0..9 while running, 10 otherwise
//   order    : current permutation, order[3i+2:3i] = job of worker i
//   perm_idx : index of the current permutation
//   busy     : enumeration in progress
//   valid    : enumeration finished, accumulator results are final
interface jam_perm_seq_if;
    import jam_pkg::*;

    logic                start;
    logic [3:0]          cnt;
    logic [ORDER_W-1:0]  order;
    logic [PERM_W-1:0]   perm_idx;
    logic                busy;
    logic                valid;

    modport master (
        input  start,
        output cnt, order, perm_idx, busy, valid
    );

    modport slave (
        output start,
        input  cnt, order, perm_idx, busy, valid
    );
endinterface

// File: rtl/jam_perm_seq_next_perm.sv
// Combinational lexicographic successor of an 8-element permutation.
//   order     : current permutation, worker 0 in bits [2:0] and most significant
//   order_nxt : next permutation (meaningless when is_last is high)
//   is_last   : no ascending pair exists, i.e. order is 7,6,5,4,3,2,1,0
module next_perm
    import jam_pkg::*;
(
    input  logic [ORDER_W-1:0] order,
    output logic [ORDER_W-1:0] order_nxt,
    output logic               is_last
);

    logic [IDX_W-1:0] p [N_WORKERS];
    logic [IDX_W-1:0] q [N_WORKERS];
    logic [IDX_W-1:0] r [N_WORKERS];
    logic [IDX_W-1:0] piv;
    logic [IDX_W-1:0] swp;
    logic [IDX_W-1:0] src;
    logic             found;

    generate
        for (genvar gi = 0; gi < N_WORKERS; gi++) begin : g_pack
            assign p[gi]                   = order[IDX_W*gi +: IDX_W];
            assign order_nxt[IDX_W*gi +: IDX_W] = r[gi];
        end
    endgenerate

    always_comb begin
        found = 1'b0;
        piv   = '0;
        swp   = 3'd7;
        src   = '0;
        // Later hits overwrite earlier ones, leaving the largest pivot index.
        for (int k = 0; k < N_WORKERS - 1; k++) begin
            if (p[k] < p[k+1]) begin
                found = 1'b1;
                piv   = 3'(k);
            end
        end
        // The suffix after the pivot is descending, so the rightmost element
        // larger than the pivot is the smallest such one.
        for (int k = 1; k < N_WORKERS; k++) begin
            if ((3'(k) > piv) && (p[k] > p[piv])) begin
                swp = 3'(k);
            end
        end
        for (int k = 0; k < N_WORKERS; k++) begin
            q[k] = p[k];
        end
        q[piv] = p[swp];
        q[swp] = p[piv];
        // Reverse the suffix: position k > piv takes element piv+8-k.
        for (int k = 0; k < N_WORKERS; k++) begin
            src  = (3'(k) > piv) ? 3'(int'(piv) + N_WORKERS - k) : 3'(k);
            r[k] = q[src];
        end
        is_last = ~found;
    end

endmodule

// File: rtl/jam_perm_seq.sv
// Producer-side sequencer: walks all 8! job assignments in lexicographic
// order, holding each for a 10-cycle accumulator window (cnt 0..9).
//   clk   : system clock
//   rst_p : synchronous active-high reset, overrides everything
//   bus   : master modport (start in; cnt, order, perm_idx, busy, valid out)
module jam_perm_seq
    import jam_pkg::*;
(
    input  logic           clk,
    input  logic           rst_p,
    jam_perm_seq_if.master bus
);

    state_e               state_reg;
    logic [3:0]           cnt_reg;
    logic [ORDER_W-1:0]   order_reg;
    logic [PERM_W-1:0]    perm_idx_reg;
    logic                 busy_reg;
    logic                 valid_reg;

    logic [ORDER_W-1:0]   order_next;
    logic                 is_last;

    next_perm u_next_perm (
        .order     (order_reg),
        .order_nxt (order_next),
        .is_last   (is_last)
    );

    always_ff @(posedge clk) begin
        if (rst_p) begin
            state_reg    <= IDLE;
            cnt_reg      <= CNT_IDLE;
            order_reg    <= ORDER_INIT;
            perm_idx_reg <= '0;
            busy_reg     <= 1'b0;
            valid_reg    <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    cnt_reg <= CNT_IDLE;
                    if (bus.start) begin
                        state_reg <= RUN;
                        cnt_reg   <= 4'd0;
                        busy_reg  <= 1'b1;
                    end
                end
                RUN: begin
                    if (cnt_reg == CNT_LAST) begin
                        if (is_last) begin
                            // Final permutation compared; order/perm_idx hold.
                            state_reg <= DONE;
                            cnt_reg   <= CNT_IDLE;
                            busy_reg  <= 1'b0;
                            valid_reg <= 1'b1;
                        end else begin
                            order_reg    <= order_next;
                            perm_idx_reg <= perm_idx_reg + 1'b1;
                            cnt_reg      <= 4'd0;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                DONE: begin
                    // Sticky: min_cost downstream can only be cleared by reset.
                    cnt_reg   <= CNT_IDLE;
                    busy_reg  <= 1'b0;
                    valid_reg <= 1'b1;
                end
                default: begin
                    state_reg <= IDLE;
                    cnt_reg   <= CNT_IDLE;
                    busy_reg  <= 1'b0;
                    valid_reg <= 1'b0;
                end
            endcase
        end
    end

    assign bus.cnt      = cnt_reg;
    assign bus.order    = order_reg;
    assign bus.perm_idx = perm_idx_reg;
    assign bus.busy     = busy_reg;
    assign bus.valid    = valid_reg;

endmodule

// File: tb/tb_jam_perm_seq.sv
module tb_jam_perm_seq;

    logic clk;
    logic rst_p;
    int   tests;
    int   failed;

    jam_perm_seq_if bus ();

    jam_perm_seq dut (
        .clk   (clk),
        .rst_p (rst_p),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        int          adv;     // clock edges to advance before sampling
        bit          start;   // start level driven before the first edge
        logic [3:0]  cnt;
        logic [23:0] order;
        logic [15:0] perm;
        bit          busy;
        bit          valid;
    } vec_t;

    vec_t vt [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Worker 0 listed first; worker i lands in bits [3i+2:3i].
    function automatic logic [23:0] pk(input int a0, a1, a2, a3, a4, a5, a6, a7);
        int a [8];
        logic [23:0] o;
        a = '{a0, a1, a2, a3, a4, a5, a6, a7};
        o = '0;
        for (int k = 0; k < 8; k++) o[3*k +: 3] = 3'(a[k]);
        return o;
    endfunction

    function automatic logic [23:0] model_next(input logic [23:0] o);
        int p [8];
        int i, j, t;
        logic [23:0] r;
        for (int k = 0; k < 8; k++) p[k] = int'(o[3*k +: 3]);
        i = -1;
        for (int k = 6; k >= 0 && i < 0; k--) if (p[k] < p[k+1]) i = k;
        j = 7;
        while (p[j] <= p[i]) j--;
        t = p[i]; p[i] = p[j]; p[j] = t;
        for (int lo = i + 1, hi = 7; lo < hi; lo++, hi--) begin
            t = p[lo]; p[lo] = p[hi]; p[hi] = t;
        end
        r = '0;
        for (int k = 0; k < 8; k++) r[3*k +: 3] = 3'(p[k]);
        return r;
    endfunction

    function automatic bit lex_gt(input logic [23:0] a, input logic [23:0] b);
        for (int k = 0; k < 8; k++) begin
            if (a[3*k +: 3] > b[3*k +: 3]) return 1'b1;
            if (a[3*k +: 3] < b[3*k +: 3]) return 1'b0;
        end
        return 1'b0;
    endfunction

    function automatic bit is_perm(input logic [23:0] o);
        logic [7:0] m;
        m = '0;
        for (int k = 0; k < 8; k++) m[o[3*k +: 3]] = 1'b1;
        return m == 8'hFF;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_p     = 1'b1;
        bus.start = 1'b0;
        repeat (2) tick();
        rst_p = 1'b0;
    endtask

    task automatic chk_state(input string n, input logic [3:0] c, input logic [23:0] o,
                             input logic [15:0] p, input bit b, input bit v);
        chk({n, ".cnt"},      32'(bus.cnt),      32'(c));
        chk({n, ".order"},    32'(bus.order),    32'(o));
        chk({n, ".perm_idx"}, 32'(bus.perm_idx), 32'(p));
        chk({n, ".busy"},     32'(bus.busy),     32'(b));
        chk({n, ".valid"},    32'(bus.valid),    32'(v));
    endtask

    initial begin
        int          cyc;
        int          nperm;
        int          inv_err;
        int          sticky_err;
        logic [23:0] prev;
        logic [23:0] init_o;

        tests  = 0;
        failed = 0;
        rst_p  = 1'b1;
        bus.start = 1'b0;
        init_o = pk(0, 1, 2, 3, 4, 5, 6, 7);

        vt[0] = '{"reset",       0,  1'b0, 4'd10, init_o,                   16'd0, 1'b0, 1'b0};
        vt[1] = '{"idle20",      20, 1'b0, 4'd10, init_o,                   16'd0, 1'b0, 1'b0};
        vt[2] = '{"start",       1,  1'b1, 4'd0,  init_o,                   16'd0, 1'b1, 1'b0};
        vt[3] = '{"cnt9",        9,  1'b0, 4'd9,  init_o,                   16'd0, 1'b1, 1'b0};
        vt[4] = '{"perm1",       1,  1'b0, 4'd0,  pk(0, 1, 2, 3, 4, 5, 7, 6), 16'd1, 1'b1, 1'b0};
        vt[5] = '{"perm5",       40, 1'b0, 4'd0,  pk(0, 1, 2, 3, 4, 7, 6, 5), 16'd5, 1'b1, 1'b0};
        vt[6] = '{"start_run",   3,  1'b1, 4'd3,  pk(0, 1, 2, 3, 4, 7, 6, 5), 16'd5, 1'b1, 1'b0};
        vt[7] = '{"perm6",       7,  1'b1, 4'd0,  pk(0, 1, 2, 3, 5, 4, 6, 7), 16'd6, 1'b1, 1'b0};

        do_reset();
        for (int v = 0; v < 8; v++) begin
            bus.start = vt[v].start;
            for (int e = 0; e < vt[v].adv; e++) begin
                tick();
                bus.start = 1'b0;
            end
            bus.start = 1'b0;
            chk_state(vt[v].name, vt[v].cnt, vt[v].order, vt[v].perm, vt[v].busy, vt[v].valid);
        end

        // Full enumeration with scoreboard.
        do_reset();
        cyc        = 0;
        nperm      = 0;
        inv_err    = 0;
        prev       = '0;
        bus.start  = 1'b1;
        while (1) begin
            tick();
            bus.start = 1'b0;
            cyc++;
            if (bus.busy && bus.valid) inv_err++;
            if (bus.cnt > 4'd10) inv_err++;
            if (bus.valid) break;
            if (cyc > 403300) begin
                chk("run_timeout", 32'(cyc), 32'd403201);
                break;
            end
            if (bus.cnt == 4'd0) begin
                nperm++;
                if (nperm == 1) begin
                    chk("first_order", 32'(bus.order), 32'(init_o));
                end else begin
                    chk("next_perm_model", 32'(bus.order), 32'(model_next(prev)));
                    chk("lex_increase", 32'(lex_gt(bus.order, prev)), 32'd1);
                end
                chk("is_permutation", 32'(is_perm(bus.order)), 32'd1);
                chk("perm_idx_seq", 32'(bus.perm_idx), 32'(nperm - 1));
                prev = bus.order;
            end else if (bus.busy && bus.order !== prev) begin
                inv_err++;
            end
        end
        chk("latency", 32'(cyc), 32'd403201);
        chk("perm_count", 32'(nperm), 32'd40320);
        chk_state("done", 4'd10, pk(7, 6, 5, 4, 3, 2, 1, 0), 16'd40319, 1'b0, 1'b1);
        chk("run_invariants", 32'(inv_err), 32'd0);

        sticky_err = 0;
        for (int k = 0; k < 100; k++) begin
            bus.start = (k % 7 == 0);
            tick();
            if (!bus.valid || bus.busy || bus.cnt != 4'd10 ||
                bus.perm_idx != 16'd40319 || bus.order != 24'h053977) sticky_err++;
        end
        bus.start = 1'b0;
        chk("done_sticky", 32'(sticky_err), 32'd0);

        // Reset in the middle of a run.
        do_reset();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (35) tick();
        chk_state("pre_rst", 4'd5, model_next(model_next(model_next(init_o))), 16'd3, 1'b1, 1'b0);
        rst_p = 1'b1;
        tick();
        chk_state("mid_rst", 4'd10, init_o, 16'd0, 1'b0, 1'b0);
        rst_p     = 1'b0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk_state("restart", 4'd0, init_o, 16'd0, 1'b1, 1'b0);
        repeat (10) tick();
        chk_state("restart_p1", 4'd0, pk(0, 1, 2, 3, 4, 5, 7, 6), 16'd1, 1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
